// File: rtl/particle_feed_pkg.sv
// rtl/particle_feed_pkg.sv - shared types and binary16 helpers for the particle frame feeder
package particle_feed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SWEEP = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SWAP  = 3'd4
    } feed_state_t;

    localparam int          FP16_EXP_MSB     = 14;
    localparam int          FP16_EXP_LSB     = 10;
    localparam logic [4:0]  FP16_EXP_SPECIAL = 5'h1F;

    // An all-ones exponent encodes Inf or NaN.
    function automatic logic fp16_is_special(input logic [15:0] i_half);
        return i_half[FP16_EXP_MSB:FP16_EXP_LSB] == FP16_EXP_SPECIAL;
    endfunction

endpackage

// File: rtl/feed_valid_pipe.sv
// rtl/feed_valid_pipe.sv - valid-bit shadow of the position RAM read pipeline
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   i_valid     a read was issued this cycle
//   o_valid     the RAM data for that read is on rd_data this cycle
//   o_empty     no read is in flight
module feed_valid_pipe #(
    parameter int RD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid,
    output logic o_valid,
    output logic o_empty
);

    logic [RD_LATENCY-1:0] r_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_valid;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_valid = r_pipe[RD_LATENCY-1];
    assign o_empty = (r_pipe == '0);

endmodule

// File: rtl/particle_frame_feeder.sv
// rtl/particle_frame_feeder.sv - per-frame particle position sweep from position RAM to renderer
//
// Optional feature macro: PARTICLE_CULL_EN (drop particles holding Inf/NaN components).
//
// Ports:
//   clk_pixel, rst_n_in     pixel clock, asynchronous active-low reset
//   frame_start_in          frame boundary pulse
//   sim_ready_in            positions stable, sweep may start
//   num_particles_in        live particle count (clamped to MAX_PARTICLES)
//   rd_en_out, rd_addr_out  position RAM read port
//   rd_data_in              RAM data, RD_LATENCY cycles after the read
//   particle_position_out   registered position, held between strobes
//   data_valid_out          one strobe per emitted particle
//   frame_swap_out          one-cycle pulse after the sweep drains
//   busy_out                sweep in progress, RAM must not be written
//   dropped_frames_out      saturating count of ignored frame starts
//   culled_count_out        particles culled in the last sweep
module particle_frame_feeder
    import particle_feed_pkg::*;
#(
    parameter int DIMS          = 2,
    parameter int MAX_PARTICLES = 1024,
    parameter int ADDR_W        = $clog2(MAX_PARTICLES),
    parameter int RD_LATENCY    = 2
) (
    input  logic                 clk_pixel,
    input  logic                 rst_n_in,
    input  logic                 frame_start_in,
    input  logic                 sim_ready_in,
    input  logic [ADDR_W:0]      num_particles_in,
    output logic                 rd_en_out,
    output logic [ADDR_W-1:0]    rd_addr_out,
    input  logic [16*DIMS-1:0]   rd_data_in,
    output logic [16*DIMS-1:0]   particle_position_out,
    output logic                 data_valid_out,
    output logic                 frame_swap_out,
    output logic                 busy_out,
    output logic [7:0]           dropped_frames_out,
    output logic [ADDR_W:0]      culled_count_out
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_PARTICLES);

    feed_state_t          r_state;
    feed_state_t          w_state_next;
    logic                 r_rst_sync;
    logic                 w_rst_n;
    logic [ADDR_W:0]      r_count;
    logic [ADDR_W-1:0]    r_addr;
    logic [16*DIMS-1:0]   r_pos;
    logic                 r_valid;
    logic [7:0]           r_dropped;
    logic                 w_latch;
    logic                 w_last_addr;
    logic                 w_pipe_valid;
    logic                 w_pipe_empty;
    logic                 w_cull;
    logic [ADDR_W:0]      w_count_clamped;

    // Assertion is immediate; release is delayed by one clk_pixel edge.
    always_ff @(posedge clk_pixel or negedge rst_n_in) begin
        if (!rst_n_in) r_rst_sync <= 1'b0;
        else           r_rst_sync <= 1'b1;
    end
    assign w_rst_n = r_rst_sync;

    assign w_latch         = (r_state == ST_ARMED) && sim_ready_in;
    assign w_count_clamped = (num_particles_in > MAX_CNT) ? MAX_CNT : num_particles_in;
    assign w_last_addr     = ({1'b0, r_addr} == (r_count - 1'b1));

    feed_valid_pipe #(.RD_LATENCY(RD_LATENCY)) u_valid_pipe (
        .clk     (clk_pixel),
        .rst_n   (w_rst_n),
        .i_valid (rd_en_out),
        .o_valid (w_pipe_valid),
        .o_empty (w_pipe_empty)
    );

    always_ff @(posedge clk_pixel or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // DRAIN leaves once the read pipe is empty: the output register is then
    // loading (or holding) its final slot, so SWAP lands right after it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (frame_start_in) w_state_next = ST_ARMED;
            ST_ARMED: if (sim_ready_in)
                          w_state_next = (num_particles_in == '0) ? ST_SWAP : ST_SWEEP;
            ST_SWEEP: if (w_last_addr) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_pipe_empty) w_state_next = ST_SWAP;
            ST_SWAP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

`ifdef PARTICLE_CULL_EN
    logic [ADDR_W:0] r_culled;

    always_comb begin
        w_cull = 1'b0;
        for (int d = 0; d < DIMS; d++) begin
            if (fp16_is_special(rd_data_in[16*d +: 16])) w_cull = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_culled <= '0;
        end else if (w_latch) begin
            r_culled <= '0;
        end else if (w_pipe_valid && w_cull) begin
            r_culled <= r_culled + 1'b1;
        end
    end
    assign culled_count_out = r_culled;
`else
    assign w_cull           = 1'b0;
    assign culled_count_out = '0;
`endif

    always_ff @(posedge clk_pixel or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_count   <= '0;
            r_addr    <= '0;
            r_pos     <= '0;
            r_valid   <= 1'b0;
            r_dropped <= '0;
        end else begin
            if (w_latch) begin
                r_count <= w_count_clamped;
                r_addr  <= '0;
            end
            // Address returns to 0 after the last read so it never wraps into stale entries.
            if (r_state == ST_SWEEP) begin
                r_addr <= w_last_addr ? '0 : r_addr + 1'b1;
            end
            r_valid <= w_pipe_valid && !w_cull;
            if (w_pipe_valid && !w_cull) begin
                r_pos <= rd_data_in;
            end
            if (frame_start_in && (r_state != ST_IDLE) && (r_dropped != 8'hFF)) begin
                r_dropped <= r_dropped + 8'd1;
            end
        end
    end

    assign rd_en_out             = (r_state == ST_SWEEP);
    assign rd_addr_out           = r_addr;
    assign particle_position_out = r_pos;
    assign data_valid_out        = r_valid;
    assign frame_swap_out        = (r_state == ST_SWAP);
    assign busy_out              = (r_state != ST_IDLE);
    assign dropped_frames_out    = r_dropped;

endmodule

// File: tb/tb_particle_frame_feeder.sv
// tb/tb_particle_frame_feeder.sv - randomized and directed bench for particle_frame_feeder
module tb_particle_frame_feeder;

    localparam int L   = 2;
    localparam int MSK = 32'h7FFF;

    logic        clk_pixel = 1'b0;
    logic        rst_n_in  = 1'b0;
    logic        frame_start_in = 1'b0;
    logic        sim_ready_in   = 1'b0;
    logic [10:0] num_particles_in = '0;
    logic        rd_en_out;
    logic [9:0]  rd_addr_out;
    logic [31:0] rd_data_in;
    logic [31:0] particle_position_out;
    logic        data_valid_out;
    logic        frame_swap_out;
    logic        busy_out;
    logic [7:0]  dropped_frames_out;
    logic [10:0] culled_count_out;

    particle_frame_feeder #(.DIMS(2), .MAX_PARTICLES(1024), .RD_LATENCY(L)) dut (
        .clk_pixel             (clk_pixel),
        .rst_n_in              (rst_n_in),
        .frame_start_in        (frame_start_in),
        .sim_ready_in          (sim_ready_in),
        .num_particles_in      (num_particles_in),
        .rd_en_out             (rd_en_out),
        .rd_addr_out           (rd_addr_out),
        .rd_data_in            (rd_data_in),
        .particle_position_out (particle_position_out),
        .data_valid_out        (data_valid_out),
        .frame_swap_out        (frame_swap_out),
        .busy_out              (busy_out),
        .dropped_frames_out    (dropped_frames_out),
        .culled_count_out      (culled_count_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Position RAM with a fixed read latency.
    logic [31:0] ram     [0:1023];
    logic [31:0] rd_pipe [0:L-1];
    always @(posedge clk_pixel) begin
        rd_pipe[0] <= rd_en_out ? ram[rd_addr_out] : $urandom;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data_in = rd_pipe[L-1];

    // Expected-event schedule, indexed by cycle number.
    bit          e_rd   [0:MSK];
    logic [9:0]  e_addr [0:MSK];
    bit          e_val  [0:MSK];
    logic [31:0] e_pos  [0:MSK];
    bit          e_swap [0:MSK];
    bit          e_cull [0:MSK];
    bit          e_clr  [0:MSK];

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_swaps = 0;
    bit          m_armed = 0;
    int          m_busy_end = -1;
    bit          m_prev_rst = 0;
    int          m_dropped = 0;
    int          m_culled = 0;
    logic [31:0] m_pos = '0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s cycle %0d got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit is_special(input logic [31:0] d);
        return ((d[15:0] & 16'h7C00) == 16'h7C00) || ((d[31:16] & 16'h7C00) == 16'h7C00);
    endfunction

    function automatic bit model_busy();
        return m_armed || (cyc <= m_busy_end);
    endfunction

    // Reference model: consumes this cycle's inputs at the clock edge and
    // schedules every future output event of the frame in one go.
    always @(posedge clk_pixel) begin
        bit busy_c;
        int n;
        int s;
        if (!rst_n_in || !m_prev_rst) begin
            m_armed = 0; m_busy_end = -1; m_dropped = 0; m_culled = 0; m_pos = '0;
            for (int i = 0; i <= MSK; i++) begin
                e_rd[i] = 0; e_val[i] = 0; e_swap[i] = 0; e_cull[i] = 0; e_clr[i] = 0;
            end
        end else begin
            busy_c = model_busy();
            if (m_armed && sim_ready_in) begin
                s = cyc;
                n = (num_particles_in > 11'd1024) ? 1024 : int'(num_particles_in);
                m_armed = 0;
                e_clr[(s+1) & MSK] = 1;
                for (int i = 0; i < n; i++) begin
                    e_rd[(s+1+i) & MSK]   = 1;
                    e_addr[(s+1+i) & MSK] = i[9:0];
`ifdef PARTICLE_CULL_EN
                    if (is_special(ram[i])) e_cull[(s+2+L+i) & MSK] = 1;
                    else begin
                        e_val[(s+2+L+i) & MSK] = 1;
                        e_pos[(s+2+L+i) & MSK] = ram[i];
                    end
`else
                    e_val[(s+2+L+i) & MSK] = 1;
                    e_pos[(s+2+L+i) & MSK] = ram[i];
`endif
                end
                m_busy_end = (n == 0) ? s + 1 : s + 2 + L + n;
                e_swap[m_busy_end & MSK] = 1;
            end
            if (frame_start_in) begin
                if (busy_c) begin
                    if (m_dropped < 255) m_dropped++;
                end else begin
                    m_armed = 1;
                end
            end
        end
        m_prev_rst = rst_n_in;
        cyc++;
    end

    always @(negedge clk_pixel) begin
        int ix;
        ix = cyc & MSK;
        if (!rst_n_in) begin
            cmp("rst_rd_en", {31'b0, rd_en_out}, 0);
            cmp("rst_valid", {31'b0, data_valid_out}, 0);
            cmp("rst_pos", particle_position_out, 0);
            cmp("rst_swap", {31'b0, frame_swap_out}, 0);
            cmp("rst_busy", {31'b0, busy_out}, 0);
        end else begin
            if (e_clr[ix])  m_culled = 0;
            if (e_cull[ix]) m_culled++;
            if (e_val[ix])  m_pos = e_pos[ix];
            cmp("rd_en", {31'b0, rd_en_out}, {31'b0, e_rd[ix]});
            if (e_rd[ix]) cmp("rd_addr", {22'b0, rd_addr_out}, {22'b0, e_addr[ix]});
            cmp("data_valid", {31'b0, data_valid_out}, {31'b0, e_val[ix]});
            cmp("position", particle_position_out, m_pos);
            cmp("frame_swap", {31'b0, frame_swap_out}, {31'b0, e_swap[ix]});
            cmp("busy", {31'b0, busy_out}, {31'b0, model_busy()});
            cmp("dropped", {24'b0, dropped_frames_out}, m_dropped);
            cmp("culled", {21'b0, culled_count_out}, m_culled);
            if (frame_swap_out) n_swaps++;
        end
        e_rd[ix] = 0; e_val[ix] = 0; e_swap[ix] = 0; e_cull[ix] = 0; e_clr[ix] = 0;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_pixel);
            #1;
        end
    endtask

    task automatic pulse_start(output int f);
        f = cyc;
        frame_start_in = 1'b1;
        step(1);
        frame_start_in = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (model_busy() && k < 3000) begin
            step(1);
            k++;
        end
        if (k >= 3000) cmp("idle_timeout", 1, 0);
        step(2);
    endtask

    task automatic do_reset();
        frame_start_in = 1'b0;
        rst_n_in = 1'b0;
        step(3);
        rst_n_in = 1'b1;
        step(3);
    endtask

    initial begin
        int f;
        int sw0;
        for (int i = 0; i < 1024; i++) ram[i] = {16'h4000 + 16'(i), 16'h3C00 + 16'(i)};
        step(2);
        cmp("reset_busy", {31'b0, busy_out}, 0);
        cmp("reset_dropped", {24'b0, dropped_frames_out}, 0);
        rst_n_in = 1'b1;
        step(3);

        // Basic 4-particle sweep.
        num_particles_in = 11'd4;
        sim_ready_in = 1'b1;
        pulse_start(f);
        cmp("basic_busy_armed", {31'b0, busy_out}, 1);
        step(1);
        cmp("basic_first_rd_en", {31'b0, rd_en_out}, 1);
        cmp("basic_first_addr", {22'b0, rd_addr_out}, 0);
        step(3);
        cmp("basic_last_addr", {22'b0, rd_addr_out}, 3);
        cmp("basic_first_valid", {31'b0, data_valid_out}, 1);
        cmp("basic_first_pos", particle_position_out, 32'h40003C00);
        step(3);
        cmp("basic_last_pos", particle_position_out, 32'h40033C03);
        step(1);
        cmp("basic_swap", {31'b0, frame_swap_out}, 1);
        cmp("basic_no_valid_at_swap", {31'b0, data_valid_out}, 0);
        step(1);
        cmp("basic_idle", {31'b0, busy_out}, 0);
        cmp("basic_hold_pos", particle_position_out, 32'h40033C03);
        step(3);

        // Zero count.
        num_particles_in = 11'd0;
        pulse_start(f);
        cmp("zero_swap_early", {31'b0, frame_swap_out}, 0);
        step(1);
        cmp("zero_swap", {31'b0, frame_swap_out}, 1);
        cmp("zero_rd_en", {31'b0, rd_en_out}, 0);
        step(3);

        // Special values in slots 1 and 2.
        ram[1] = {16'h7C00, 16'h4000};
        ram[2] = {16'h3C00, 16'h7E00};
        num_particles_in = 11'd4;
        pulse_start(f);
        step(5);
`ifdef PARTICLE_CULL_EN
        cmp("cull_slot1_valid", {31'b0, data_valid_out}, 0);
`else
        cmp("cull_slot1_valid", {31'b0, data_valid_out}, 1);
`endif
        step(3);
        cmp("cull_swap", {31'b0, frame_swap_out}, 1);
        step(1);
`ifdef PARTICLE_CULL_EN
        cmp("cull_count", {21'b0, culled_count_out}, 2);
`else
        cmp("cull_count", {21'b0, culled_count_out}, 0);
`endif
        step(3);

        // Blocked start.
        sim_ready_in = 1'b0;
        num_particles_in = 11'd5;
        pulse_start(f);
        step(20);
        cmp("blocked_busy", {31'b0, busy_out}, 1);
        cmp("blocked_rd_en", {31'b0, rd_en_out}, 0);
        sim_ready_in = 1'b1;
        step(1);
        cmp("blocked_start_rd_en", {31'b0, rd_en_out}, 1);
        wait_idle();

        // Random traffic against the model.
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        for (int k = 0; k < 400; k++) begin
            frame_start_in   = ($urandom_range(0, 7) == 0);
            sim_ready_in     = ($urandom_range(0, 2) != 0);
            num_particles_in = 11'($urandom_range(0, 12));
            step(1);
        end
        frame_start_in = 1'b0;
        sim_ready_in = 1'b1;
        wait_idle();

        // Dropped frames and saturation.
        do_reset();
        for (int i = 0; i < 1024; i++) ram[i] = {16'h4000 + 16'(i), 16'h3C00 + 16'(i)};
        num_particles_in = 11'd100;
        sw0 = n_swaps;
        pulse_start(f);
        for (int k = 0; k < 3; k++) begin
            step(15);
            frame_start_in = 1'b1;
            step(1);
            frame_start_in = 1'b0;
        end
        wait_idle();
        cmp("dropped_three", {24'b0, dropped_frames_out}, 3);
        cmp("single_swap", n_swaps - sw0, 1);
        for (int k = 0; k < 700; k++) begin
            frame_start_in = k[0];
            step(1);
        end
        frame_start_in = 1'b0;
        wait_idle();
        cmp("dropped_saturated", {24'b0, dropped_frames_out}, 255);

        // Clamp to MAX_PARTICLES.
        num_particles_in = 11'd2000;
        pulse_start(f);
        step(1 + 1023);
        cmp("clamp_last_addr", {22'b0, rd_addr_out}, 1023);
        cmp("clamp_last_rd_en", {31'b0, rd_en_out}, 1);
        step(1);
        cmp("clamp_drain_rd_en", {31'b0, rd_en_out}, 0);
        wait_idle();

        // Reset mid-sweep.
        pulse_start(f);
        step(1 + 500);
        cmp("midreset_addr", {22'b0, rd_addr_out}, 500);
        sw0 = n_swaps;
        rst_n_in = 1'b0;
        #1;
        cmp("midreset_rd_en", {31'b0, rd_en_out}, 0);
        cmp("midreset_addr0", {22'b0, rd_addr_out}, 0);
        cmp("midreset_busy", {31'b0, busy_out}, 0);
        cmp("midreset_valid", {31'b0, data_valid_out}, 0);
        cmp("midreset_pos", particle_position_out, 0);
        cmp("midreset_dropped", {24'b0, dropped_frames_out}, 0);
        step(2);
        rst_n_in = 1'b1;
        step(3);
        cmp("midreset_no_swap", n_swaps - sw0, 0);
        num_particles_in = 11'd6;
        pulse_start(f);
        step(1);
        cmp("restart_rd_en", {31'b0, rd_en_out}, 1);
        cmp("restart_addr", {22'b0, rd_addr_out}, 0);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cycle %0d got timeout expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/particle_frame_feeder.md
Name: particle_frame_feeder

Overview:
- Per-frame particle source for the renderer. Placed between the particle position RAM, which the simulator writes, and the renderer's transform stage.
- On each frame-start pulse, and once the simulator reports positions stable, streams every particle's binary16 position one per cycle with a valid strobe.
- After the last particle, emits a one-cycle frame_swap pulse so the renderer flips its double buffer.

Parameters:
- DIMS, 2, number of binary16 components per particle.
- MAX_PARTICLES, 1024, position RAM depth.
- ADDR_W, $clog2(MAX_PARTICLES), RAM address width.
- RD_LATENCY, 2, cycles from rd_en_out/rd_addr_out to valid rd_data_in. Legal range 1..4.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- rst_n_in  in  1  asynchronous, active-low reset.
- frame_start_in  in  1  one-cycle pulse at frame boundary (renderer frame_drawn).
- sim_ready_in  in  1  level; high = positions stable, sweep may start.
- num_particles_in  in  ADDR_W+1  live particle count.
- rd_en_out  out  1  RAM read enable.
- rd_addr_out  out  ADDR_W  RAM read address.
- rd_data_in  in  16*DIMS  RAM read data, packed {dim[DIMS-1]..dim0}.
- particle_position_out  out  16*DIMS  position to renderer.
- data_valid_out  out  1  one-cycle strobe per emitted particle.
- frame_swap_out  out  1  one-cycle pulse after the sweep fully drains.
- busy_out  out  1  high in any state other than IDLE; simulator must not write the RAM while high.
- dropped_frames_out  out  8  saturating count of ignored frame_start pulses.
- culled_count_out  out  ADDR_W+1  particles culled in the last sweep.

Behaviour:
- Reset: all outputs 0; state IDLE; read-valid pipe cleared. Reset mid-sweep aborts with no frame_swap_out. Deassertion is synchronised internally, so the first active edge is one cycle after release.
- FSM states: IDLE, ARMED, SWEEP, DRAIN, SWAP.
- IDLE to ARMED: on frame_start_in.
- ARMED to SWEEP: when sim_ready_in=1. On that edge, latch count = min(num_particles_in, MAX_PARTICLES) and clear culled_count_out.
- ARMED to SWAP: when sim_ready_in=1 and the latched count is 0.
- SWEEP: rd_en_out=1, rd_addr_out runs 0..count-1, one address per cycle. When the address count-1 is issued, go to DRAIN. Addresses never wrap.
- DRAIN: rd_en_out=0. Wait until the RD_LATENCY valid pipe and the output register are empty, then go to SWAP.
- SWAP: frame_swap_out=1 for exactly one cycle, then IDLE.
- Latency: address issued at cycle t gives data_valid_out at t+RD_LATENCY+1, because the output is registered. The sweep of N particles produces N back-to-back valid cycles. frame_swap_out fires on the cycle after the last data_valid_out.
- particle_position_out holds its last value when data_valid_out=0.
- frame_start_in in any state other than IDLE, including the SWAP cycle, is ignored. dropped_frames_out increments and saturates at 255.
- sim_ready_in falling during SWEEP has no effect; the sweep completes.
- num_particles_in changes after the latch edge have no effect until the next sweep.

Optional Feature:
- Macro PARTICLE_CULL_EN.
- Defined: a particle is culled if any component has exponent 5'h1F (Inf/NaN). For a culled particle, data_valid_out stays 0 in its slot and culled_count_out increments. Sweep timing is unchanged and frame_swap_out still fires on schedule.
- Undefined: every particle passes through and culled_count_out is tied to 0.

Decomposition:
- Package particle_feed_pkg:
  - state enum feed_state_t;
  - FP16_EXP_MSB/LSB constants;
  - FP16_EXP_SPECIAL = 5'h1F;
  - function fp16_is_special().
- Sub-module feed_valid_pipe: parameterised RD_LATENCY shift register carrying the valid bit, with an "empty" output used by DRAIN.

Test Plan:
- Basic sweep: reset, num_particles=4, sim_ready=1, RAM[i]={16'h4000+i,16'h3C00+i}, pulse frame_start at cycle 10. Expect rd_addr 0..3 at cycles 12..15 and data_valid at 15..18 with the matching positions. Expect frame_swap at 19.
- Zero count: num_particles=0. Expect frame_swap two cycles after frame_start, and no rd_en or data_valid.
- Blocked start: sim_ready=0 for 20 cycles after frame_start. Expect busy=1 throughout with no reads; the sweep starts the cycle after sim_ready rises.
- Dropped frames: pulse frame_start 3 times during a 100-particle sweep. Expect dropped_frames=3 and a single frame_swap. Then 300 extra pulses during sweeps leave dropped_frames saturated at 255.
- Clamp and reset: num_particles=2000 gives the last address 1023. Asserting rst_n_in low at address 500 immediately zeroes all outputs, produces no frame_swap, and the next frame restarts at address 0.
- PARTICLE_CULL_EN: RAM[1]={16'h7C00,16'h4000}, RAM[2]={16'h3C00,16'h7E00}, N=4. Expect data_valid only for particles 0 and 3, culled_count=2, and frame_swap at the same cycle as the uncull case.
